dpe_demultiplexer: RTL

Packet-level AXI-Stream demultiplexer for the data-plane engine. It is the counterpart of `dpe_multiplexer`: one `dpe_if` input stream is steered to one of five `dpe_if` output streams. The destination is taken from the first beat of each packet and held until `tlast`. Packets addressed to a non-existent port are dropped and counted. A `pause`/`paused` pair lets the control plane quiesce the block on a packet boundary.

---
 rtl/dpe_demultiplexer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dpe_demultiplexer.sv
// rtl/dpe_demultiplexer.sv - packet-level stream demultiplexer, one input to five outputs
// Destination comes from tuser[2:0] of the first beat; invalid destinations are dropped and counted.
module dpe_demultiplexer #(
  parameter int TDATA_WIDTH = 128,
  parameter int TUSER_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pause,
  output logic                     paused,
  output logic [15:0]              drop_cnt,
  input  logic [TDATA_WIDTH-1:0]   inp_tdata,
  input  logic [TDATA_WIDTH/8-1:0] inp_tkeep,
  input  logic [TUSER_WIDTH-1:0]   inp_tuser,
  input  logic                     inp_tlast,
  input  logic                     inp_tvalid,
  output logic                     inp_tready,
  output logic [TDATA_WIDTH-1:0]   out0_tdata,
  output logic [TDATA_WIDTH/8-1:0] out0_tkeep,
  output logic [TUSER_WIDTH-1:0]   out0_tuser,
  output logic                     out0_tlast,
  output logic                     out0_tvalid,
  input  logic                     out0_tready,
  output logic [TDATA_WIDTH-1:0]   out1_tdata,
  output logic [TDATA_WIDTH/8-1:0] out1_tkeep,
  output logic [TUSER_WIDTH-1:0]   out1_tuser,
  output logic                     out1_tlast,
  output logic                     out1_tvalid,
  input  logic                     out1_tready,
  output logic [TDATA_WIDTH-1:0]   out2_tdata,
  output logic [TDATA_WIDTH/8-1:0] out2_tkeep,
  output logic [TUSER_WIDTH-1:0]   out2_tuser,
  output logic                     out2_tlast,
  output logic                     out2_tvalid,
  input  logic                     out2_tready,
  output logic [TDATA_WIDTH-1:0]   out3_tdata,
  output logic [TDATA_WIDTH/8-1:0] out3_tkeep,
  output logic [TUSER_WIDTH-1:0]   out3_tuser,
  output logic                     out3_tlast,
  output logic                     out3_tvalid,
  input  logic                     out3_tready,
  output logic [TDATA_WIDTH-1:0]   out4_tdata,
  output logic [TDATA_WIDTH/8-1:0] out4_tkeep,
  output logic [TUSER_WIDTH-1:0]   out4_tuser,
  output logic                     out4_tlast,
  output logic                     out4_tvalid,
  input  logic                     out4_tready
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t                   state;
  logic [2:0]               dest_q;
  logic [2:0]               hold_sel;
  logic                     hold_valid;
  logic [TDATA_WIDTH-1:0]   hold_tdata;
  logic [TDATA_WIDTH/8-1:0] hold_tkeep;
  logic [TUSER_WIDTH-1:0]   hold_tuser;
  logic                     hold_tlast;

  logic                     sel_ready;
  logic                     can_load;
  logic                     first_ok;
  logic                     accept;
  logic                     load;

  always_comb begin
    sel_ready = 1'b0;
    case (hold_sel)
      3'd0:    sel_ready = out0_tready;
      3'd1:    sel_ready = out1_tready;
      3'd2:    sel_ready = out2_tready;
      3'd3:    sel_ready = out3_tready;
      3'd4:    sel_ready = out4_tready;
      default: sel_ready = 1'b0;
    endcase
  end

  // Drain and reload can happen on the same edge, even toward a different port.
  assign can_load = !hold_valid || sel_ready;
  assign first_ok = (inp_tuser[2:0] <= 3'd4);

  always_comb begin
    inp_tready = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:    inp_tready = !pause && can_load;
        FWD:     inp_tready = can_load;
        DROP:    inp_tready = 1'b1;
        default: inp_tready = 1'b0;
      endcase
    end
  end

  assign accept = inp_tvalid && inp_tready;
  assign load   = accept && ((state == IDLE && first_ok) || state == FWD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dest_q     <= 3'd0;
      hold_sel   <= 3'd0;
      hold_valid <= 1'b0;
      hold_tdata <= '0;
      hold_tkeep <= '0;
      hold_tuser <= '0;
      hold_tlast <= 1'b0;
      paused     <= 1'b0;
      drop_cnt   <= 16'd0;
    end else begin
      paused <= pause && (state == IDLE) && !hold_valid;

      if (load) begin
        hold_valid <= 1'b1;
        hold_tdata <= inp_tdata;
        hold_tkeep <= inp_tkeep;
        hold_tuser <= inp_tuser;
        hold_tlast <= inp_tlast;
        hold_sel   <= (state == IDLE) ? inp_tuser[2:0] : dest_q;
      end else if (hold_valid && sel_ready) begin
        hold_valid <= 1'b0;
      end

      if (accept) begin
        case (state)
          IDLE: begin
            if (first_ok) begin
              dest_q <= inp_tuser[2:0];
              if (!inp_tlast) state <= FWD;
            end else begin
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
              if (!inp_tlast) state <= DROP;
            end
          end
          FWD, DROP: if (inp_tlast) state <= IDLE;
          default:   state <= IDLE;
        endcase
      end
    end
  end

  assign out0_tvalid = hold_valid && (hold_sel == 3'd0);
  assign out1_tvalid = hold_valid && (hold_sel == 3'd1);
  assign out2_tvalid = hold_valid && (hold_sel == 3'd2);
  assign out3_tvalid = hold_valid && (hold_sel == 3'd3);
  assign out4_tvalid = hold_valid && (hold_sel == 3'd4);

  assign out0_tdata = hold_tdata;
  assign out1_tdata = hold_tdata;
  assign out2_tdata = hold_tdata;
  assign out3_tdata = hold_tdata;
  assign out4_tdata = hold_tdata;
  assign out0_tkeep = hold_tkeep;
  assign out1_tkeep = hold_tkeep;
  assign out2_tkeep = hold_tkeep;
  assign out3_tkeep = hold_tkeep;
  assign out4_tkeep = hold_tkeep;
  assign out0_tuser = hold_tuser;
  assign out1_tuser = hold_tuser;
  assign out2_tuser = hold_tuser;
  assign out3_tuser = hold_tuser;
  assign out4_tuser = hold_tuser;
  assign out0_tlast = hold_tlast;
  assign out1_tlast = hold_tlast;
  assign out2_tlast = hold_tlast;
  assign out3_tlast = hold_tlast;
  assign out4_tlast = hold_tlast;

endmodule
